// File: rtl/rca_slice_sequencer.sv
// rca_slice_sequencer: WIDTH-bit add/subtract computed over WIDTH/SLICE cycles
// on one SLICE-bit ripple-carry slice, least-significant slice first.
// Ports:
//    clk, rst            clock, synchronous active-high reset
//    in_valid/in_ready   operand handshake (a, b, c_in, sub)
//    out_valid/out_ready result handshake (sum, c_out, overflow)
//    sub=0: a+b+c_in     sub=1: a-b as a+~b+1 (c_out=1 means no borrow)
module rca_slice_sequencer #(
   parameter int WIDTH = 32,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             overflow
);
   localparam int N  = WIDTH / SLICE;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_a, r_b, r_sum;
   logic [IW-1:0]    r_idx;
   logic             r_carry, r_cout, r_ovf;
   logic [SLICE-1:0] w_as, w_bs;
   logic [SLICE:0]   w_slice;
   logic             w_last, w_msb_cin;
   assign w_as    = r_a[r_idx*SLICE +: SLICE];
   assign w_bs    = r_b[r_idx*SLICE +: SLICE];
   assign w_slice = {1'b0, w_as} + {1'b0, w_bs} + {{SLICE{1'b0}}, r_carry};
   assign w_last  = r_idx == IW'(N - 1);
   // Carry into the slice's top bit, recovered from its sum bit; on the last
   // slice this is the carry into bit WIDTH-1.
   assign w_msb_cin = w_as[SLICE-1] ^ w_bs[SLICE-1] ^ w_slice[SLICE-1];
   assign sum      = r_sum;
   assign c_out    = r_cout;
   assign overflow = r_ovf;
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end
   always_comb begin
      w_next = (r_state == S_IDLE) ? (in_valid  ? S_RUN  : S_IDLE) :
               (r_state == S_RUN)  ? (w_last    ? S_DONE : S_RUN)  :
                                     (out_ready ? S_IDLE : S_DONE);
   end
   always_comb begin
      in_ready  = r_state == S_IDLE;
      out_valid = r_state == S_DONE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (r_state == S_IDLE && in_valid) begin
         r_a     <= a;
         r_b     <= sub ? ~b : b;
         r_carry <= sub ? 1'b1 : c_in;
         r_idx   <= '0;
         r_sum   <= '0;
      end else if (r_state == S_RUN) begin
         r_sum[r_idx*SLICE +: SLICE] <= w_slice[SLICE-1:0];
         r_carry <= w_slice[SLICE];
         r_idx   <= r_idx + IW'(1);
         if (w_last) begin
            r_cout <= w_slice[SLICE];
            r_ovf  <= w_msb_cin ^ w_slice[SLICE];
         end
      end
   end
endmodule

// File: tb/tb_rca_slice_sequencer.sv
// tb_rca_slice_sequencer: directed and random operations checked against an arithmetic model.
module tb_rca_slice_sequencer;
   localparam int LAT = 8;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        c_in = 1'b0;
   logic        sub = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] sum;
   logic        c_out;
   logic        overflow;
   int          n_chk = 0;
   int          n_pass = 0;

   rca_slice_sequencer dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .c_out(c_out), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   // {overflow, c_out, sum} of a +/- b in plain 33-bit arithmetic
   function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                         input logic ci, input logic s);
      logic [32:0] full;
      logic [31:0] yy;
      logic        ov;
      yy   = s ? ~y : y;
      full = {1'b0, x} + {1'b0, yy} + {32'd0, s ? 1'b1 : ci};
      ov   = (x[31] == yy[31]) && (full[31] != x[31]);
      return {ov, full};
   endfunction

   task automatic scramble();
      a    = $urandom;
      b    = $urandom;
      c_in = 1'($urandom_range(0, 1));
      sub  = 1'($urandom_range(0, 1));
   endtask

   task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic ci,
                        input logic s, input int hold, input string tag);
      logic [33:0] e;
      int          lat;
      e = model(x, y, ci, s);
      @(negedge clk);
      check({"rdy_", tag}, {31'd0, in_ready}, 32'd1);
      a = x; b = y; c_in = ci; sub = s; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      scramble();
      lat = 0;
      while (!out_valid && lat < 40) begin
         check({"busy_", tag}, {31'd0, in_ready}, 32'd0);
         @(negedge clk);
         lat++;
         scramble();
         in_valid = 1'($urandom_range(0, 1));
      end
      check({"lat_", tag}, lat, LAT);
      check({"sum_", tag}, sum, e[31:0]);
      check({"cout_", tag}, {31'd0, c_out}, {31'd0, e[32]});
      check({"ovf_", tag}, {31'd0, overflow}, {31'd0, e[33]});
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         scramble();
         in_valid = 1'($urandom_range(0, 1));
         check({"hold_vld_", tag}, {31'd0, out_valid}, 32'd1);
         check({"hold_rdy_", tag}, {31'd0, in_ready}, 32'd0);
         check({"hold_sum_", tag}, sum, e[31:0]);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({"rel_rdy_", tag}, {31'd0, in_ready}, 32'd1);
      check({"rel_vld_", tag}, {31'd0, out_valid}, 32'd0);
      check({"rel_sum_", tag}, sum, e[31:0]);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_sum", sum, 32'd0);
      check("rst_cout", {31'd0, c_out}, 32'd0);
      check("rst_ovf", {31'd0, overflow}, 32'd0);
      check("rst_vld", {31'd0, out_valid}, 32'd0);
      check("rst_rdy", {31'd0, in_ready}, 32'd1);
      do_op(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, "xslice");
      do_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 0, "ripple");
      do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, "sovf");
      do_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 0, "sub_borrow");
      do_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 0, "sub_ovf");
      do_op(32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b0, 5, "backpress");
      do_op(32'd3, 32'd4, 1'b0, 1'b0, 0, "after_bp");
      @(negedge clk);
      a = 32'h1234_5678; b = 32'h1; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_sum", sum, 32'd0);
      check("abort_vld", {31'd0, out_valid}, 32'd0);
      check("abort_rdy", {31'd0, in_ready}, 32'd1);
      do_op(32'd1, 32'd1, 1'b0, 1'b0, 0, "post_abort");
      for (int k = 0; k < 25; k++)
         do_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 2), "rand");
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/rca_slice_sequencer.md
Name: rca_slice_sequencer

Overview:
- Multi-cycle add/subtract controller. It performs a WIDTH-bit operation by reusing one SLICE-bit ripple-carry adder slice for WIDTH/SLICE consecutive cycles, least-significant slice first.
- The carry is held in a register between slices.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Trades latency for area against the full-width ripple-carry adder.

Parameters:
WIDTH, 32, operand/result width; must be an integer multiple of SLICE
SLICE, 4, bits processed per cycle by the internal adder slice; must be ≥1

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand set presented
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
c_in  input  1  carry-in for add (ignored when sub=1)
sub  input  1  0: A+B+c_in; 1: A−B (A + ~B + 1)
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
c_out  output  1  carry out of MSB (for sub: 1 = no borrow)
overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; slice index=0; carry reg=0.
  - sum=0, c_out=0, overflow=0, out_valid=0; in_ready=1 on the following cycle.
  - Reset during RUN or DONE aborts the operation; the partial result is discarded.
- States: IDLE, RUN, DONE. Outputs are registered or decoded from state only; no combinational path from in_valid/out_ready to in_ready/out_valid.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1, the block:
    - latches a;
    - latches b, or ~b when sub=1;
    - loads the carry reg with c_in (sub=0) or 1 (sub=1);
    - clears the slice index and the sum register;
    - goes to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each edge adds slice i (bits [i*SLICE+SLICE-1 : i*SLICE]) of the latched operands plus the carry reg.
  - It writes those sum bits, stores the slice carry-out in the carry reg, and increments i.
  - On the edge that processes slice WIDTH/SLICE−1, the block:
    - sets c_out to that slice's carry-out;
    - sets overflow to (carry into bit WIDTH−1) XOR c_out;
    - goes to DONE.
  - Inputs a, b, sub, c_in are ignored during RUN; a change on them must not affect the result.
- DONE:
  - out_valid=1; sum, c_out, overflow are stable.
  - Holds indefinitely while out_ready=0.
  - On an edge with out_ready=1, goes to IDLE. sum, c_out, overflow keep their values until the next accept.
- Latency: accept edge k → out_valid first high after edge k+WIDTH/SLICE (8 cycles at defaults). Minimum initiation interval is WIDTH/SLICE+2 cycles, because there is no overlap between operations.
- Arithmetic:
  - Modulo 2^WIDTH.
  - The carry chain is fully sequential: slice i uses the carry-out of slice i−1.
  - No bit of the result may be written by more than one slice, and every bit must be written.
- Simultaneous events:
  - out_ready asserted outside DONE is ignored.
  - in_valid outside IDLE is ignored; the producer must hold in_valid until it sees in_ready.
- SLICE=WIDTH is legal: a single RUN cycle.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles → sum=0, c_out=0, overflow=0, out_valid=0, in_ready=1 afterward.
2. Add with cross-slice carry:
   - Stimulus: a=0x0000_FFFF, b=0x0000_0001, c_in=0, sub=0.
   - Required: after exactly 8 cycles, out_valid=1, sum=0x0001_0000, c_out=0, overflow=0.
3. Full carry ripple and signed overflow:
   - Stimulus 1: a=0xFFFF_FFFF, b=0, c_in=1 → sum=0, c_out=1, overflow=0.
   - Stimulus 2: a=0x7FFF_FFFF, b=1, c_in=0 → sum=0x8000_0000, c_out=0, overflow=1.
4. Subtract:
   - Stimulus 1: a=5, b=7, sub=1 → sum=0xFFFF_FFFE, c_out=0 (borrow), overflow=0.
   - Stimulus 2: a=0x8000_0000, b=1, sub=1 → sum=0x7FFF_FFFF, c_out=1, overflow=1.
5. Backpressure:
   - Stimulus: hold out_ready=0 for 5 cycles in DONE, toggling a/b/in_valid meanwhile.
   - Required: out_valid stays 1, result unchanged, in_ready=0. After the out_ready=1 edge, in_ready=1 and the next operation (3+4) yields 7.
6. Reset mid-operation:
   - Stimulus: assert rst at RUN slice 3.
   - Required: next cycle state IDLE, sum=0, out_valid=0, in_ready=1. A subsequent 1+1 yields 2 with normal 8-cycle latency.
